// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity selectors, legal
// oversampling ratios and the default frame width used by both TX and RX.
package uart_pkg;

   localparam int UART_DATA_WIDTH = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

   function automatic logic majority3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter with a three-point majority vote around the
// bit centre; bit_done strobes on the last oversample tick of each bit.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  run,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  sampled_bit,
   output logic                  bit_done
);

   logic [PRESCALE_W-1:0] edge_cnt_reg;
   logic [PRESCALE_W-1:0] last_cnt;
   logic [PRESCALE_W-1:0] mid_cnt;
   logic [2:0]            smp_vec;

   assign last_cnt = prescale - PRESCALE_W'(1);
   assign mid_cnt  = prescale >> 1;
   assign bit_done = run && (edge_cnt_reg == last_cnt);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         edge_cnt_reg <= '0;
      else if (!run || bit_done)
         edge_cnt_reg <= '0;
      else
         edge_cnt_reg <= edge_cnt_reg + PRESCALE_W'(1);
   end

   // Sample points sit at P/2-1, P/2 and P/2+1.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_smp
         logic                  smp_reg;
         logic [PRESCALE_W-1:0] pt;
         assign pt = mid_cnt + PRESCALE_W'(gi) - PRESCALE_W'(1);
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST)
               smp_reg <= 1'b1;
            else if (run && (edge_cnt_reg == pt))
               smp_reg <= rx_in;
         end
         assign smp_vec[gi] = smp_reg;
      end
   endgenerate

   assign sampled_bit = majority3(smp_vec);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, LSB-first deserialiser, parity/stop checking and
// registered result pulses issued one cycle after the stop bit ends.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [2:0]            state_reg;
   logic [BW-1:0]         bit_cnt_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [PRESCALE_W-1:0] prescale_reg;
   logic [PRESCALE_W-1:0] prescale_eff;
   logic                  par_en_reg;
   logic                  par_typ_reg;
   logic                  par_flag_reg;
   logic                  result_pending_reg;
   logic                  result_stop_reg;
   logic                  result_par_reg;
   logic                  run;
   logic                  frame_start;
   logic                  sampled_bit;
   logic                  bit_done;
   logic                  exp_par;

   assign frame_start  = (state_reg == ST_IDLE) && !rx_in;
   assign run          = (state_reg != ST_IDLE) || !rx_in;
   // The detection cycle is edge 0 of the start bit, before the latch takes effect.
   assign prescale_eff = (state_reg == ST_IDLE) ? prescale : prescale_reg;
   assign exp_par      = (par_typ_reg == PAR_EVEN) ? ^data_reg : ~^data_reg;

   uart_rx_sampler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_sampler (
      .CLK         (CLK),
      .RST         (RST),
      .run         (run),
      .rx_in       (rx_in),
      .prescale    (prescale_eff),
      .sampled_bit (sampled_bit),
      .bit_done    (bit_done)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg          <= ST_IDLE;
         bit_cnt_reg        <= '0;
         data_reg           <= '0;
         prescale_reg       <= '0;
         par_en_reg         <= 1'b0;
         par_typ_reg        <= 1'b0;
         par_flag_reg       <= 1'b0;
         result_pending_reg <= 1'b0;
         result_stop_reg    <= 1'b0;
         result_par_reg     <= 1'b0;
      end else begin
         result_pending_reg <= 1'b0;
         if (frame_start) begin
            prescale_reg <= prescale;
            par_en_reg   <= par_en;
            par_typ_reg  <= par_typ;
         end
         case (state_reg)
            ST_IDLE: begin
               if (frame_start) begin
                  state_reg    <= ST_START;
                  par_flag_reg <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  state_reg   <= sampled_bit ? ST_IDLE : ST_DATA;
                  bit_cnt_reg <= '0;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  data_reg[bit_cnt_reg] <= sampled_bit;
                  if (bit_cnt_reg == BW'(DATA_WIDTH - 1))
                     state_reg <= par_en_reg ? ST_PARITY : ST_STOP;
                  else
                     bit_cnt_reg <= bit_cnt_reg + BW'(1);
               end
            end
            ST_PARITY: begin
               if (bit_done) begin
                  par_flag_reg <= (sampled_bit != exp_par);
                  state_reg    <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (bit_done) begin
                  result_pending_reg <= 1'b1;
                  result_stop_reg    <= sampled_bit;
                  result_par_reg     <= par_flag_reg;
                  par_flag_reg       <= 1'b0;
                  state_reg          <= rx_in ? ST_IDLE : ST_START;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         p_data     <= '0;
         data_valid <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         data_valid <= result_pending_reg && result_stop_reg && !result_par_reg;
         par_err    <= result_pending_reg && result_par_reg;
         stp_err    <= result_pending_reg && !result_stop_reg;
         if (result_pending_reg && result_stop_reg && !result_par_reg)
            p_data <= data_reg;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised at the line level and
// each expected result is queued when its frame is launched.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int DW = 8;
   localparam int PW = 6;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          rx_in = 1'b1;
   logic [PW-1:0] prescale = PW'(8);
   logic          par_en = 1'b0;
   logic          par_typ = 1'b0;
   logic [DW-1:0] p_data;
   logic          data_valid;
   logic          par_err;
   logic          stp_err;

   uart_rx #(
      .DATA_WIDTH (DW),
      .PRESCALE_W (PW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .rx_in      (rx_in),
      .prescale   (prescale),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       dv;
      logic       pe;
      logic       se;
   } exp_t;

   exp_t       sb_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] last_good = 8'h00;
   int         start_cyc = 0;
   int         dv_cyc_last = 0;
   int         dv_cyc_prev = 0;
   bit         prev_pulse = 1'b0;

   always @(negedge CLK) begin
      exp_t e;
      if (RST && (data_valid || par_err || stp_err)) begin
         vectors++;
         if (prev_pulse) begin
            miscompares++;
            $display("FAIL pulse_width: output pulse held longer than 1 cycle at cycle %0d", cyc);
         end
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL spurious: dv=%b pe=%b se=%b p_data=%h, required no pulse", data_valid, par_err, stp_err, p_data);
         end else begin
            e = sb_q.pop_front();
            if ({data_valid, par_err, stp_err, p_data} !== {e.dv, e.pe, e.se, e.data}) begin
               miscompares++;
               $display("FAIL frame: dv=%b pe=%b se=%b p_data=%h, required dv=%b pe=%b se=%b p_data=%h",
                        data_valid, par_err, stp_err, p_data, e.dv, e.pe, e.se, e.data);
            end else begin
               $display("frame ok: dv=%b pe=%b se=%b p_data=%h at cycle %0d", data_valid, par_err, stp_err, p_data, cyc);
            end
         end
         if (data_valid) begin
            dv_cyc_prev = dv_cyc_last;
            dv_cyc_last = cyc;
         end
      end
      prev_pulse = data_valid || par_err || stp_err;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input int p, input bit pe_en, input bit ptyp,
                             input bit flip_par, input bit stop_v, input int glitch_bit);
      exp_t e;
      logic par_bit;
      par_bit = (ptyp ? ~^d : ^d) ^ flip_par;
      e.pe = pe_en && flip_par;
      e.se = !stop_v;
      e.dv = !e.pe && !e.se;
      if (e.dv) last_good = d;
      e.data = last_good;
      sb_q.push_back(e);
      prescale  = PW'(p);
      par_en    = pe_en;
      par_typ   = ptyp;
      start_cyc = cyc;
      rx_in = 1'b0;
      tick(p);
      for (int b = 0; b < 8; b++) begin
         for (int j = 0; j < p; j++) begin
            rx_in = (b == glitch_bit && j == p / 2) ? ~d[b] : d[b];
            tick(1);
         end
      end
      if (pe_en) begin
         rx_in = par_bit;
         tick(p);
      end
      rx_in = stop_v;
      tick(p);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         tick(1);
         n++;
      end
      vectors++;
      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing_result: %0d results outstanding after %0d cycles, required 0", sb_q.size(), budget);
         sb_q.delete();
      end
   endtask

   task automatic test_reset;
      RST = 1'b0;
      tick(3);
      vectors++;
      if ({p_data, data_valid, par_err, stp_err} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_state: p_data=%h dv=%b pe=%b se=%b, required all 0", p_data, data_valid, par_err, stp_err);
      end
      RST = 1'b1;
      tick(3);
   endtask

   task automatic test_basic_p8;
      send_frame(8'hA5, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
      wait_drain(10);
      vectors++;
      if (dv_cyc_last - start_cyc - 1 !== 80) begin
         miscompares++;
         $display("FAIL latency_p8: data_valid %0d cycles after start edge, required 80", dv_cyc_last - start_cyc - 1);
      end
      rx_in = 1'b1;
      tick(5);
   endtask

   task automatic test_parity_p16;
      send_frame(8'h3C, PRESCALE_16, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1);
      wait_drain(10);
      send_frame(8'h3C, PRESCALE_16, 1'b1, PAR_EVEN, 1'b1, 1'b1, -1);
      wait_drain(10);
      rx_in = 1'b1;
      tick(5);
   endtask

   task automatic test_stop_err_p32;
      send_frame(8'h01, PRESCALE_32, 1'b1, PAR_ODD, 1'b0, 1'b0, -1);
      rx_in = 1'b1;
      wait_drain(10);
      tick(80);
   endtask

   task automatic test_false_start;
      prescale = PW'(PRESCALE_8);
      par_en   = 1'b0;
      rx_in    = 1'b0;
      tick(2);
      rx_in = 1'b1;
      tick(10);
      vectors++;
      if (dut.state_reg !== ST_IDLE) begin
         miscompares++;
         $display("FAIL false_start_idle: state=%0d, required %0d", dut.state_reg, ST_IDLE);
      end
      send_frame(8'h5A, PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
      wait_drain(10);
      rx_in = 1'b1;
      tick(5);
   endtask

   task automatic test_back_to_back;
      send_frame(8'h55, PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
      send_frame(8'hAA, PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
      wait_drain(10);
      vectors++;
      if (dv_cyc_last - dv_cyc_prev !== 160) begin
         miscompares++;
         $display("FAIL back_to_back_spacing: pulses %0d cycles apart, required 160", dv_cyc_last - dv_cyc_prev);
      end
      rx_in = 1'b1;
      tick(5);
   endtask

   task automatic test_mid_frame_reset;
      logic [7:0] d;
      d = 8'h96;
      prescale = PW'(PRESCALE_16);
      par_en   = 1'b0;
      rx_in    = 1'b0;
      tick(16);
      for (int b = 0; b < 4; b++) begin
         rx_in = d[b];
         tick(16);
      end
      rx_in = d[4];
      tick(8);
      RST = 1'b0;
      #1;
      vectors++;
      if ({p_data, data_valid, par_err, stp_err} !== 11'd0 || dut.state_reg !== ST_IDLE) begin
         miscompares++;
         $display("FAIL mid_frame_reset: p_data=%h dv=%b pe=%b se=%b state=%0d, required all 0 and idle",
                  p_data, data_valid, par_err, stp_err, dut.state_reg);
      end
      rx_in = 1'b1;
      tick(4);
      RST = 1'b1;
      last_good = 8'h00;
      tick(4);
      send_frame(8'hC3, PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1);
      wait_drain(10);
      rx_in = 1'b1;
      tick(5);
   endtask

   task automatic test_majority_glitch;
      send_frame(8'h96, PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 3);
      wait_drain(10);
      rx_in = 1'b1;
      tick(3);
      send_frame(8'h3C, PRESCALE_8, 1'b1, PAR_ODD, 1'b0, 1'b1, 6);
      wait_drain(10);
      rx_in = 1'b1;
      tick(5);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      @(negedge CLK);
      test_reset();
      test_basic_p8();
      test_parity_p16();
      test_stop_err_p32();
      test_false_start();
      test_back_to_back();
      test_mid_frame_reset();
      test_majority_glitch();
      tick(20);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
